wb_button_led_ctrl: RTL
=======================

Name: wb_button_led_ctrl

Overview:
Wishbone responder in the user project area that owns the pad-facing end of the button/LED interface. It synchronises and debounces three button inputs (mprj_io[9:7]) and records press/release events. It drives eight LEDs (mprj_io[17:10]) either from a firmware-written register or from a hardware press counter. It raises an interrupt on enabled button presses.

Parameters:
BASE_ADDR, 32'h3000_0000, word-aligned base of the 32-byte register window
DEBOUNCE_CYCLES, 16'd1000, consecutive stable cycles needed to accept a button change (minimum 2)
CNT_W, 16, width of the debounce counter (must hold DEBOUNCE_CYCLES)

Ports:
wb_clk_i  in  1  system clock, all logic on rising edge
wb_rst_i  in  1  reset; synchronous, active-high
wbs_stb_i  in  1  Wishbone strobe
wbs_cyc_i  in  1  Wishbone cycle
wbs_we_i  in  1  write enable
wbs_sel_i  in  4  byte selects
wbs_adr_i  in  32  byte address
wbs_dat_i  in  32  write data
wbs_ack_o  out  1  acknowledge
wbs_dat_o  out  32  read data
buttons_i  in  3  raw asynchronous button levels, active-high
leds_o  out  8  LED drive
leds_oeb_o  out  8  pad output-enable-bar, constant 8'h00
irq_o  out  1  level interrupt

Behaviour:
- Reset: wbs_ack_o=0, wbs_dat_o=0, leds_o=0, irq_o=0. All registers, flags, counters and sync flops clear; debounced state = 3'b000.
- Address decode: hit = cyc & stb & (adr[31:5]==BASE_ADDR[31:5]); offset = adr[4:2]. Non-hit strobes are never acked.
- Handshake: on hit with ack low, ack asserts the next cycle for exactly one cycle. The write takes effect on that edge; read data is valid with ack. Ack is low for at least one cycle between transfers, so back-to-back strobes are acked every 2nd cycle. wbs_dat_o returns to 0 when ack is low.
- Writes honour wbs_sel_i per byte. Reads ignore sel.
- Register map (offset):
  0 LED [7:0] RW.
  1 BTN [2:0] RO, debounced state. Writes are ignored.
  2 EVT [2:0] rise flags, [10:8] fall flags, W1C.
  3 CTRL [0] auto_mode, [6:4] irq_en per button rise; RW.
  4 CNT [7:0] RO rise count, any-value write clears it.
  5-7: read 0, writes ignored, still acked.
- Sync: each button uses a 2-flop synchroniser; the raw-to-sync latency is 2 cycles.
- Debounce, per button: if sync != stable, the counter increments; otherwise the counter is 0. When the counter reaches DEBOUNCE_CYCLES-1 and sync still differs, stable <= sync, the counter goes to 0, and a 1-cycle rise or fall pulse is generated. A glitch shorter than DEBOUNCE_CYCLES never changes stable.
- Events: a rise pulse sets EVT rise bit i; a fall pulse sets fall bit i. If a W1C clear and a set hit the same bit in the same cycle, the set wins.
- CNT: increments by the number of rise pulses in the cycle (0-3) and wraps modulo 256. If a clear-write and rise pulses land in the same cycle, CNT = number of those pulses.
- leds_o = auto_mode ? CNT : LED register, registered, 1 cycle after the source changes. Toggling auto_mode does not alter the LED register contents.
- irq_o = |(EVT rise[2:0] & irq_en), registered. It deasserts the cycle after the W1C write clears the enabled flags.
- Reset asserted mid-transfer: ack drops next edge, the transfer is discarded, and the master must re-issue it.

Test Plan:
- Reset then read offsets 0-4 -> all 0, ack exactly 1 cycle after stb, leds_o=8'h00, irq_o=0.
- Write LED=32'h0000_00A5 with sel=4'b0001 -> leds_o=8'hA5 one cycle after ack. Repeat with sel=4'b0000 -> leds_o stays 8'hA5.
- DEBOUNCE_CYCLES=8: buttons_i=3'b111 for 5 cycles then 0 -> BTN=0, EVT=0. Hold 3'b111 for 20 cycles -> BTN=3'b111, EVT=32'h0000_0007, CNT=3.
- CTRL=32'h11, press button0 ten times (each press ≥8 cycles high and ≥8 low) -> leds_o=8'd10 (auto mode), irq_o=1. Write EVT=32'h1 -> irq_o=0 next cycle. Fall flag bit8 stays set.
- 256 presses in auto mode -> CNT wraps to 0. Write to CNT in the same cycle as a rise pulse -> CNT=1. W1C of rise bit0 in the same cycle as a new rise pulse -> bit stays 1.
- Assert wb_rst_i during an outstanding read with stb high -> no ack, all outputs 0 next cycle. Re-issued read of BTN acks normally.

Source files
------------

// File: rtl/wb_button_led_ctrl.sv
// Wishbone-controlled button/LED block: synchronises and debounces three buttons,
// latches press/release events, drives eight LEDs and raises a press interrupt.
module wb_button_led_ctrl #(
  parameter logic [31:0] BASE_ADDR       = 32'h3000_0000,
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd1000,
  parameter int          CNT_W           = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic [2:0]  buttons_i,
  output logic [7:0]  leds_o,
  output logic [7:0]  leds_oeb_o,
  output logic        irq_o
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 16'd1);

  // Handshake: a decoded cyc&stb with ack low is accepted; ack_q pulses high for
  // exactly one cycle on the following edge, which is also the edge the write
  // commits and the read data appears. ack then stays low for at least one cycle.
  logic                  ack_q, ack_d;
  logic [31:0]           dat_q, dat_d;
  logic [2:0]            sync1_q, sync1_d, sync2_q, sync2_d;
  logic [2:0]            stable_q, stable_d;
  logic [2:0][CNT_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [7:0]            led_q, led_d;
  logic [5:0]            evt_q, evt_d;   // {fall[2:0], rise[2:0]}
  logic                  auto_q, auto_d;
  logic [2:0]            irq_en_q, irq_en_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [7:0]            leds_q, leds_d;
  logic                  irq_q, irq_d;

  logic                  hit, access, wr;
  logic [2:0]            offset;
  logic [2:0]            rise, fall;
  logic [5:0]            evt_clr;
  logic [7:0]            rise_cnt;
  logic [31:0]           rdata;
  logic                  unused_bits;

  assign unused_bits = ^{wbs_adr_i[1:0], wbs_sel_i[3:2], wbs_dat_i[31:11]};

  always_comb begin
    hit    = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:5] == BASE_ADDR[31:5]);
    offset = wbs_adr_i[4:2];
    access = hit & ~ack_q;
    wr     = access & wbs_we_i;

    sync1_d = buttons_i;
    sync2_d = sync1_q;

    // A change is accepted only after it has been seen for DEBOUNCE_CYCLES edges.
    for (int i = 0; i < 3; i++) begin
      stable_d[i]  = stable_q[i];
      deb_cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (deb_cnt_q[i] == DEB_LAST) stable_d[i] = sync2_q[i];
        else deb_cnt_d[i] = deb_cnt_q[i] + CNT_W'(1);
      end
    end
    rise     = stable_d & ~stable_q;
    fall     = ~stable_d & stable_q;
    rise_cnt = {7'd0, rise[0]} + {7'd0, rise[1]} + {7'd0, rise[2]};

    led_d = led_q;
    if (wr && offset == 3'd0 && wbs_sel_i[0]) led_d = wbs_dat_i[7:0];

    evt_clr = '0;
    if (wr && offset == 3'd2) begin
      if (wbs_sel_i[0]) evt_clr[2:0] = wbs_dat_i[2:0];
      if (wbs_sel_i[1]) evt_clr[5:3] = wbs_dat_i[10:8];
    end
    evt_d = (evt_q & ~evt_clr) | {fall, rise};

    auto_d   = auto_q;
    irq_en_d = irq_en_q;
    if (wr && offset == 3'd3 && wbs_sel_i[0]) begin
      auto_d   = wbs_dat_i[0];
      irq_en_d = wbs_dat_i[6:4];
    end

    cnt_d = ((wr && offset == 3'd4) ? 8'd0 : cnt_q) + rise_cnt;

    leds_d = auto_q ? cnt_q : led_q;
    irq_d  = |(evt_q[2:0] & irq_en_q);

    case (offset)
      3'd0:    rdata = {24'd0, led_q};
      3'd1:    rdata = {29'd0, stable_q};
      3'd2:    rdata = {21'd0, evt_q[5:3], 5'd0, evt_q[2:0]};
      3'd3:    rdata = {25'd0, irq_en_q, 3'd0, auto_q};
      3'd4:    rdata = {24'd0, cnt_q};
      default: rdata = 32'd0;
    endcase

    ack_d = access;
    dat_d = (access && !wbs_we_i) ? rdata : 32'd0;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q     <= 1'b0;
      dat_q     <= '0;
      sync1_q   <= '0;
      sync2_q   <= '0;
      stable_q  <= '0;
      deb_cnt_q <= '0;
      led_q     <= '0;
      evt_q     <= '0;
      auto_q    <= 1'b0;
      irq_en_q  <= '0;
      cnt_q     <= '0;
      leds_q    <= '0;
      irq_q     <= 1'b0;
    end else begin
      ack_q     <= ack_d;
      dat_q     <= dat_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      stable_q  <= stable_d;
      deb_cnt_q <= deb_cnt_d;
      led_q     <= led_d;
      evt_q     <= evt_d;
      auto_q    <= auto_d;
      irq_en_q  <= irq_en_d;
      cnt_q     <= cnt_d;
      leds_q    <= leds_d;
      irq_q     <= irq_d;
    end
  end

  assign wbs_ack_o  = ack_q;
  assign wbs_dat_o  = dat_q;
  assign leds_o     = leds_q;
  assign leds_oeb_o = 8'h00;
  assign irq_o      = irq_q;

endmodule
